// File: rtl/key_schedule_ctrl_if.sv
// Handshake bundle for key_schedule_ctrl: expansion control plus the round-key read port.
// The master side drives start/key and read requests; the slave side is the key-schedule engine.
interface key_schedule_ctrl_if #(
  parameter int nk = 4
);
  logic              start;
  logic [32*nk-1:0]  key;
  logic              busy;
  logic              done;
  logic              keys_ready;
  logic              rk_req;
  logic [3:0]        rk_round;
  logic              rk_valid;
  logic              rk_err;
  logic [127:0]      rk_out;

  modport master (
    output start, key, rk_req, rk_round,
    input  busy, done, keys_ready, rk_valid, rk_err, rk_out
  );

  modport slave (
    input  start, key, rk_req, rk_round,
    output busy, done, keys_ready, rk_valid, rk_err, rk_out
  );
endinterface

// File: rtl/key_schedule_ctrl.sv
// Iterative AES key expansion: one schedule word per clock through a single shared subword
// datapath, with the full schedule held internally and served as 128-bit round keys.
module key_schedule_ctrl #(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  key_schedule_ctrl_if.slave bus
);
  localparam int         W        = 4 * (nr + 1);
  localparam logic [5:0] LAST_IDX = 6'(W - 1);
  localparam logic [5:0] NK_IDX   = 6'(nk);
  localparam logic [2:0] NK_LAST  = 3'(nk - 1);
  localparam logic [3:0] NR_MAX   = 4'(nr);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_e       state_q, state_d;
  logic [5:0]   i_q, i_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         keys_ready_q, keys_ready_d;
  logic         rk_valid_q, rk_valid_d;
  logic         rk_err_q, rk_err_d;
  logic [127:0] rk_out_q, rk_out_d;

  logic [31:0]  w_q [W];
  logic         start_acc_s;
  logic         wr_en_s;
  logic         rk_ok_s;
  logic [5:0]   rk_idx_s;
  logic [31:0]  t_s, prev_s, sub_in_s, sub_out_s, new_word_s;

  // cnt_q tracks i mod nk so the non-power-of-two nk=6 case needs no divider
  assign start_acc_s = bus.start && (state_q != ST_EXPAND);
  assign rk_idx_s    = {bus.rk_round, 2'b00};
  assign rk_ok_s     = bus.rk_req && keys_ready_q && (bus.rk_round <= NR_MAX);

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      i_q          <= 6'd0;
      cnt_q        <= 3'd0;
      rcon_q       <= 8'h01;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      keys_ready_q <= 1'b0;
      rk_valid_q   <= 1'b0;
      rk_err_q     <= 1'b0;
      rk_out_q     <= 128'd0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      cnt_q        <= cnt_d;
      rcon_q       <= rcon_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      keys_ready_q <= keys_ready_d;
      rk_valid_q   <= rk_valid_d;
      rk_err_q     <= rk_err_d;
      rk_out_q     <= rk_out_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_acc_s) state_d = ST_EXPAND;
        else             state_d = state_q;
      end
      ST_EXPAND: begin
        if (i_q == LAST_IDX) state_d = ST_DONE;
        else                 state_d = ST_EXPAND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Single shared subword path; its input is muxed between rotword(t) and t
  always_comb begin
    t_s    = w_q[i_q - 6'd1];
    prev_s = w_q[i_q - NK_IDX];
    if (cnt_q == 3'd0) sub_in_s = {t_s[23:0], t_s[31:24]};
    else               sub_in_s = t_s;
    sub_out_s = sub_word(sub_in_s);
    if (cnt_q == 3'd0)                  new_word_s = prev_s ^ sub_out_s ^ {rcon_q, 24'h000000};
    else if (nk == 8 && cnt_q == 3'd4)  new_word_s = prev_s ^ sub_out_s;
    else                                new_word_s = prev_s ^ t_s;
  end

  // Output and counter next values
  always_comb begin
    i_d          = i_q;
    cnt_d        = cnt_q;
    rcon_d       = rcon_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    keys_ready_d = keys_ready_q;
    wr_en_s      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_acc_s) begin
          i_d          = NK_IDX;
          cnt_d        = 3'd0;
          rcon_d       = 8'h01;
          busy_d       = 1'b1;
          keys_ready_d = 1'b0;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_EXPAND: begin
        wr_en_s = 1'b1;
        i_d     = i_q + 6'd1;
        if (cnt_q == NK_LAST) cnt_d = 3'd0;
        else                  cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd0) rcon_d = xtime(rcon_q);
        else               rcon_d = rcon_q;
        if (i_q == LAST_IDX) begin
          busy_d       = 1'b0;
          done_d       = 1'b1;
          keys_ready_d = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase

    rk_valid_d = 1'b0;
    rk_err_d   = 1'b0;
    rk_out_d   = rk_out_q;
    if (rk_ok_s) begin
      rk_valid_d = 1'b1;
      rk_out_d   = {w_q[rk_idx_s], w_q[rk_idx_s + 6'd1], w_q[rk_idx_s + 6'd2], w_q[rk_idx_s + 6'd3]};
    end else if (bus.rk_req) begin
      rk_err_d = 1'b1;
    end else begin
      rk_err_d = 1'b0;
    end
  end

  // Schedule storage: key load on accepted start, one expanded word per EXPAND cycle
  always_ff @(posedge clk) begin
    if (start_acc_s) begin
      for (int k = 0; k < nk; k++) begin
        w_q[k] <= bus.key[32*(nk-k)-1 -: 32];
      end
    end else if (wr_en_s) begin
      w_q[i_q] <= new_word_s;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.keys_ready = keys_ready_q;
  assign bus.rk_valid   = rk_valid_q;
  assign bus.rk_err     = rk_err_q;
  assign bus.rk_out     = rk_out_q;
endmodule
